// File: rtl/match_control.sv
// rtl/match_control.sv - penalty shoot-out round sequencer: turn order, pause, tally and result
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   start          pulse, begins a new match from IDLE or OVER
//   abort          pulse, returns to IDLE from any state (wins over start)
//   shot_done      pulse, player's kick finished (honoured only in SHOOT)
//   shot_scored    qualifies shot_done: player scored
//   keep_done      pulse, keeper turn finished (honoured only in KEEP)
//   keep_conceded  qualifies keep_done: enemy scored
//   phase          0 IDLE, 1 SHOOTER, 2 KEEPER, 3 PAUSE, 4 OVER
//   turn_start     1-cycle pulse on entry to a shooter or keeper turn
//   score_player   player goals
//   score_enemy    enemy goals
//   kicks_player   player kicks taken
//   kicks_enemy    enemy kicks taken
//   match_over     high while the result is held
//   player_won     valid while match_over
//   draw           valid while match_over

module match_control #(
    parameter int REG_ROUNDS  = 5,
    parameter int MAX_ROUNDS  = 15,
    parameter int PAUSE_TICKS = 13003901
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       shot_done,
    input  logic       shot_scored,
    input  logic       keep_done,
    input  logic       keep_conceded,
    output logic [2:0] phase,
    output logic       turn_start,
    output logic [3:0] score_player,
    output logic [3:0] score_enemy,
    output logic [3:0] kicks_player,
    output logic [3:0] kicks_enemy,
    output logic       match_over,
    output logic       player_won,
    output logic       draw
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHOOT = 3'd1,
        S_KEEP  = 3'd2,
        S_EVAL  = 3'd3,
        S_PAUSE = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_SHOOT = 3'd1;
    localparam logic [2:0] PH_KEEP  = 3'd2;
    localparam logic [2:0] PH_PAUSE = 3'd3;
    localparam logic [2:0] PH_OVER  = 3'd4;

    // Pause counter only has to reach PAUSE_TICKS-1.
    localparam int CW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_TICKS - 1);

    // Decision arithmetic is done at 6 bits so "e + (REG - ke)" cannot overflow.
    localparam logic [5:0] REG6 = 6'(REG_ROUNDS);
    localparam logic [3:0] MAX4 = 4'(MAX_ROUNDS);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   pause_cnt;
    logic            pause_last;

    logic [5:0]      p6;
    logic [5:0]      e6;
    logic [5:0]      kp6;
    logic [5:0]      ke6;
    logic            in_regulation;
    logic            reg_decided;
    logic            sudden_decided;
    logic            cap_decided;
    logic            decided;
    state_t          next_turn;
    logic [2:0]      phase_next;

    assign pause_last = (pause_cnt == PAUSE_LAST);

    // ------------------------------------------------------------------
    // Shoot-out rules, evaluated on the tallies already updated for the
    // turn that just finished (they are registered on entry to EVAL).
    // ------------------------------------------------------------------
    always_comb begin
        p6  = {2'b00, score_player};
        e6  = {2'b00, score_enemy};
        kp6 = {2'b00, kicks_player};
        ke6 = {2'b00, kicks_enemy};

        in_regulation = (kp6 <= REG6) && (ke6 <= REG6);
        reg_decided   = 1'b0;
        if (in_regulation) begin
            // One side leads by more than the other side still has kicks left.
            reg_decided = (p6 > e6 + (REG6 - ke6)) || (e6 > p6 + (REG6 - kp6));
        end

        sudden_decided = (kicks_player == kicks_enemy) && (kp6 >= REG6) &&
                         (score_player != score_enemy);
        cap_decided    = (kicks_player == MAX4) && (kicks_enemy == MAX4);

        decided = reg_decided || sudden_decided || cap_decided;

        // The keeper follows whenever the player is a kick ahead.
        next_turn = (kicks_player > kicks_enemy) ? S_KEEP : S_SHOOT;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and the phase value that goes with it
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start)      next_state = S_SHOOT;
                S_SHOOT: if (shot_done)  next_state = S_EVAL;
                S_KEEP:  if (keep_done)  next_state = S_EVAL;
                S_EVAL:  next_state = decided ? S_OVER : S_PAUSE;
                S_PAUSE: if (pause_last) next_state = next_turn;
                S_OVER:  if (start)      next_state = S_SHOOT;
                default: next_state = S_IDLE;
            endcase
        end

        case (next_state)
            S_IDLE:  phase_next = PH_IDLE;
            S_SHOOT: phase_next = PH_SHOOT;
            S_KEEP:  phase_next = PH_KEEP;
            S_EVAL:  phase_next = phase;      // keep showing the turn just played
            S_PAUSE: phase_next = PH_PAUSE;
            S_OVER:  phase_next = PH_OVER;
            default: phase_next = PH_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, tallies and pause counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase        <= PH_IDLE;
            turn_start   <= 1'b0;
            score_player <= 4'd0;
            score_enemy  <= 4'd0;
            kicks_player <= 4'd0;
            kicks_enemy  <= 4'd0;
            match_over   <= 1'b0;
            player_won   <= 1'b0;
            draw         <= 1'b0;
            pause_cnt    <= '0;
        end else begin
            phase      <= phase_next;
            turn_start <= (next_state != state) &&
                          ((next_state == S_SHOOT) || (next_state == S_KEEP));

            if (!abort && (state == S_PAUSE) && !pause_last) begin
                pause_cnt <= pause_cnt + CW'(1);
            end else begin
                pause_cnt <= '0;
            end

            if (abort) begin
                // Tallies are left intact so the aborted score stays visible.
                match_over <= 1'b0;
                player_won <= 1'b0;
                draw       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_OVER: begin
                        if (start) begin
                            score_player <= 4'd0;
                            score_enemy  <= 4'd0;
                            kicks_player <= 4'd0;
                            kicks_enemy  <= 4'd0;
                            match_over   <= 1'b0;
                            player_won   <= 1'b0;
                            draw         <= 1'b0;
                        end
                    end
                    S_SHOOT: begin
                        // A coincident keep_done is dropped here by construction.
                        if (shot_done) begin
                            kicks_player <= kicks_player + 4'd1;
                            score_player <= score_player + {3'b000, shot_scored};
                        end
                    end
                    S_KEEP: begin
                        if (keep_done) begin
                            kicks_enemy <= kicks_enemy + 4'd1;
                            score_enemy <= score_enemy + {3'b000, keep_conceded};
                        end
                    end
                    S_EVAL: begin
                        if (decided) begin
                            match_over <= 1'b1;
                            player_won <= (score_player > score_enemy);
                            draw       <= (score_player == score_enemy);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
